// File: rtl/mips_pipe_pkg.sv
// Shared constants, FSM state type and register-match helpers for the MIPS pipeline controls.
package mips_pipe_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic {MW_IDLE, MW_WAIT} mw_state_e;

  // $0 is hardwired, so a write to it can never be a real producer.
  function automatic logic reg_hit(input logic [4:0] w_dst, input logic [4:0] w_src);
    return (w_dst != REG_ZERO) && (w_dst == w_src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] w_src,
                                         input logic w_rw_mem, input logic [4:0] w_dst_mem,
                                         input logic w_rw_wb,  input logic [4:0] w_dst_wb);
    if (w_rw_mem && reg_hit(w_dst_mem, w_src)) return FWD_MEM;
    if (w_rw_wb  && reg_hit(w_dst_wb,  w_src)) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait tracker: freezes the pipe on a MEM-stage miss, times out after MEM_TIMEOUT waits.
module mem_wait_fsm
  import mips_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic mem_req_mem,
  input  logic mem_ready,
  output logic freeze,
  output logic mem_error
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  mw_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_miss;
  logic          w_timeout;

  assign w_miss    = mem_req_mem & ~mem_ready;
  // The IDLE miss cycle counts as the first wait, so WAIT with r_cnt == LAST is wait number MEM_TIMEOUT+1.
  assign w_timeout = (r_state == MW_WAIT) && w_miss && (r_cnt == LAST);
  assign freeze    = reset & w_miss & ~w_timeout;
  assign mem_error = r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= MW_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        MW_IDLE: begin
          if (w_miss) begin
            r_state <= MW_WAIT;
            r_cnt   <= '0;
          end
        end
        MW_WAIT: begin
          if (mem_ready) begin
            r_state <= MW_IDLE;
          end else if (w_timeout) begin
            r_state <= MW_IDLE;
            r_err   <= 1'b1;
          end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= MW_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding/sequencing controller for the 5-stage MIPS pipe.
// HAZARD_PERF_CNT_EN adds saturating stall/flush/wait performance counters.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             branch_id,
  input  logic             jump_id,
  input  logic [1:0]       pc_src_id,
  input  logic [4:0]       rs_ex,
  input  logic [4:0]       rt_ex,
  input  logic [4:0]       write_reg_ex,
  input  logic             reg_write_ex,
  input  logic             mem_to_reg_ex,
  input  logic [4:0]       write_reg_mem,
  input  logic             reg_write_mem,
  input  logic             mem_to_reg_mem,
  input  logic             mem_req_mem,
  input  logic [4:0]       write_reg_wb,
  input  logic             reg_write_wb,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_ex,
  output logic             flush_id,
  output logic             freeze,
  output logic [1:0]       pc_src_out,
  output logic [1:0]       forward_a_ex,
  output logic [1:0]       forward_b_ex,
  output logic             mem_error
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  logic w_freeze;
  logic w_lu;
  logic w_bh;
  logic w_dstall;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clock       (clock),
    .reset       (reset),
    .mem_req_mem (mem_req_mem),
    .mem_ready   (mem_ready),
    .freeze      (w_freeze),
    .mem_error   (mem_error)
  );

  assign w_lu = mem_to_reg_ex &&
                (reg_hit(write_reg_ex, rs_id) || reg_hit(write_reg_ex, rt_id));
  // Branch operands are compared in ID, so an ALU result still in EX or a load in MEM is too late.
  assign w_bh = (branch_id || jump_id) &&
                ((reg_write_ex   && reg_hit(write_reg_ex,  rs_id)) ||
                 (mem_to_reg_mem && reg_hit(write_reg_mem, rs_id)));
  assign w_dstall = w_lu || w_bh;
  assign freeze   = w_freeze;

  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    flush_ex     = 1'b0;
    flush_id     = 1'b0;
    pc_src_out   = 2'b00;
    forward_a_ex = FWD_REG;
    forward_b_ex = FWD_REG;
    if (reset) begin
      if (w_freeze) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (w_dstall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end else begin
        pc_src_out = pc_src_id;
        flush_id   = |pc_src_id;
      end
      forward_a_ex = fwd_sel(rs_ex, reg_write_mem, write_reg_mem, reg_write_wb, write_reg_wb);
      forward_b_ex = fwd_sel(rt_ex, reg_write_mem, write_reg_mem, reg_write_wb, write_reg_wb);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_wait_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_dstall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_id && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_freeze && (r_wait_cnt  != '1)) r_wait_cnt  <= r_wait_cnt  + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign wait_cnt  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed cases then randomized traffic vs a reference model.
module tb_pipeline_hazard_ctrl;

  localparam int T  = 4;
  localparam int CW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b0;
  logic [4:0] rs_id = '0, rt_id = '0, rs_ex = '0, rt_ex = '0;
  logic [4:0] write_reg_ex = '0, write_reg_mem = '0, write_reg_wb = '0;
  logic branch_id = 0, jump_id = 0, reg_write_ex = 0, mem_to_reg_ex = 0;
  logic reg_write_mem = 0, mem_to_reg_mem = 0, mem_req_mem = 0, reg_write_wb = 0, mem_ready = 0;
  logic [1:0] pc_src_id = '0;
  logic stall_if, stall_id, flush_ex, flush_id, freeze, mem_error;
  logic [1:0] pc_src_out, forward_a_ex, forward_b_ex;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .rs_id(rs_id), .rt_id(rt_id), .branch_id(branch_id), .jump_id(jump_id), .pc_src_id(pc_src_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .write_reg_ex(write_reg_ex),
    .reg_write_ex(reg_write_ex), .mem_to_reg_ex(mem_to_reg_ex),
    .write_reg_mem(write_reg_mem), .reg_write_mem(reg_write_mem),
    .mem_to_reg_mem(mem_to_reg_mem), .mem_req_mem(mem_req_mem),
    .write_reg_wb(write_reg_wb), .reg_write_wb(reg_write_wb), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .flush_ex(flush_ex), .flush_id(flush_id),
    .freeze(freeze), .pc_src_out(pc_src_out),
    .forward_a_ex(forward_a_ex), .forward_b_ex(forward_b_ex), .mem_error(mem_error)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs_id, rt_id;
    logic       br, jp;
    logic [1:0] pcs;
    logic [4:0] rs_ex, rt_ex, wr_ex;
    logic       rw_ex, m2r_ex;
    logic [4:0] wr_mem;
    logic       rw_mem, m2r_mem, req;
    logic [4:0] wr_wb;
    logic       rw_wb, rdy;
  } stim_t;

  typedef struct packed {
    logic          sif, sid, fex, fid, frz;
    logic [1:0]    pc, fa, fb;
    logic          err;
    logic [CW-1:0] sc, fc, wc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state: waits spent on the current access, sticky error, event totals.
  int   m_waited = 0;
  bit   m_err = 0;
  bit   m_drop = 0;
  int   m_sc = 0, m_fc = 0, m_wc = 0;

  function automatic bit produces(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 0) && (dst == src);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    bit   miss, frz, ds;
    @(posedge clock);
    #1;
    reset = s.rst; rs_id = s.rs_id; rt_id = s.rt_id; branch_id = s.br; jump_id = s.jp;
    pc_src_id = s.pcs; rs_ex = s.rs_ex; rt_ex = s.rt_ex; write_reg_ex = s.wr_ex;
    reg_write_ex = s.rw_ex; mem_to_reg_ex = s.m2r_ex; write_reg_mem = s.wr_mem;
    reg_write_mem = s.rw_mem; mem_to_reg_mem = s.m2r_mem; mem_req_mem = s.req;
    write_reg_wb = s.wr_wb; reg_write_wb = s.rw_wb; mem_ready = s.rdy;
    e = '0;
    m_drop = 0;
    if (!s.rst) begin
      m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0; m_wc = 0;
    end else begin
      e.err = m_err;
      e.sc  = m_sc; e.fc = m_fc; e.wc = m_wc;
      miss = s.req && !s.rdy;
      frz  = 0;
      if (miss && m_waited == T) begin
        m_err = 1; m_waited = 0; m_drop = 1;
      end else if (miss) begin
        frz = 1; m_waited++;
      end else begin
        m_waited = 0;
      end
      ds = (s.m2r_ex && (produces(s.wr_ex, s.rs_id) || produces(s.wr_ex, s.rt_id))) ||
           ((s.br || s.jp) && ((s.rw_ex && produces(s.wr_ex, s.rs_id)) ||
                               (s.m2r_mem && produces(s.wr_mem, s.rs_id))));
      e.frz = frz;
      if (frz) begin
        e.sif = 1; e.sid = 1;
      end else if (ds) begin
        e.sif = 1; e.sid = 1; e.fex = 1;
      end else begin
        e.pc  = s.pcs;
        e.fid = (s.pcs != 0);
      end
      e.fa = (s.rw_mem && produces(s.wr_mem, s.rs_ex)) ? 2'b10 :
             (s.rw_wb  && produces(s.wr_wb,  s.rs_ex)) ? 2'b01 : 2'b00;
      e.fb = (s.rw_mem && produces(s.wr_mem, s.rt_ex)) ? 2'b10 :
             (s.rw_wb  && produces(s.wr_wb,  s.rt_ex)) ? 2'b01 : 2'b00;
      if (ds)    m_sc++;
      if (e.fid) m_fc++;
      if (frz)   m_wc++;
    end
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall_if",   64'(stall_if),     64'(e.sif));
      chk("stall_id",   64'(stall_id),     64'(e.sid));
      chk("flush_ex",   64'(flush_ex),     64'(e.fex));
      chk("flush_id",   64'(flush_id),     64'(e.fid));
      chk("freeze",     64'(freeze),       64'(e.frz));
      chk("pc_src_out", 64'(pc_src_out),   64'(e.pc));
      chk("forward_a",  64'(forward_a_ex), 64'(e.fa));
      chk("forward_b",  64'(forward_b_ex), 64'(e.fb));
      chk("mem_error",  64'(mem_error),    64'(e.err));
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt",  64'(stall_cnt),    64'(e.sc));
      chk("flush_cnt",  64'(flush_cnt),    64'(e.fc));
      chk("wait_cnt",   64'(wait_cnt),     64'(e.wc));
`endif
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  initial begin
    stim_t s;
    // Reset held low with a load-use pattern and a miss on the inputs: everything must read 0.
    s = idle(); s.rst = 0; s.m2r_ex = 1; s.wr_ex = 2; s.rs_id = 2; s.req = 1; s.pcs = 2'b11;
    s.rw_mem = 1; s.wr_mem = 3; s.rs_ex = 3;
    drive(s); drive(s);
    drive(idle());

    // Load-use: one bubble, then clear.
    s = idle(); s.m2r_ex = 1; s.wr_ex = 2; s.rs_id = 2; s.rw_ex = 1;
    drive(s);
    drive(idle());

    // Branch on an EX ALU result: redirect withheld, then released.
    s = idle(); s.br = 1; s.rs_id = 5; s.pcs = 2'b01; s.rw_ex = 1; s.wr_ex = 5;
    drive(s);
    s.wr_ex = 0;
    drive(s);
    // Branch on an EX load: lu, then bh through the MEM load term, then released.
    s = idle(); s.br = 1; s.rs_id = 7; s.m2r_ex = 1; s.rw_ex = 1; s.wr_ex = 7;
    drive(s);
    s = idle(); s.br = 1; s.rs_id = 7; s.m2r_mem = 1; s.wr_mem = 7; s.pcs = 2'b01;
    drive(s);
    s = idle(); s.br = 1; s.rs_id = 7; s.pcs = 2'b01;
    drive(s);

    // Forwarding: MEM beats WB, WB when MEM targets $0, nothing for rs_ex = $0.
    s = idle(); s.rs_ex = 3; s.rt_ex = 3; s.rw_mem = 1; s.wr_mem = 3; s.rw_wb = 1; s.wr_wb = 3;
    drive(s);
    s.wr_mem = 0;
    drive(s);
    s.rs_ex = 0;
    drive(s);

    // Memory wait of 3 cycles, then completion.
    s = idle(); s.req = 1;
    repeat (3) drive(s);
    s.rdy = 1;
    drive(s);
    drive(idle());
    // Hit in the same cycle: no freeze.
    drive(s);

    // Timeout: T frozen cycles, then the timeout cycle, then sticky error, then reset clears.
    s = idle(); s.req = 1;
    repeat (T + 1) drive(s);
    repeat (3) drive(idle());
    s = idle(); s.rst = 0;
    drive(s);
    drive(idle());

    // Reset in the middle of a wait aborts it with no error.
    s = idle(); s.req = 1;
    repeat (2) drive(s);
    s.rst = 0;
    drive(s);
    drive(idle());

    // dstall and freeze together: freeze has priority.
    s = idle(); s.m2r_ex = 1; s.wr_ex = 2; s.rs_id = 2; s.jp = 1; s.pcs = 2'b10; s.req = 1;
    drive(s);
    s.rdy = 1;
    drive(s);
    drive(idle());

    // Randomized traffic over a small register set so matches are frequent.
    for (int i = 0; i < 2000; i++) begin
      s = idle();
      s.rst    = ($urandom_range(0, 199) != 0);
      s.rs_id  = 5'($urandom_range(0, 3)); s.rt_id = 5'($urandom_range(0, 3));
      s.br     = 1'($urandom_range(0, 1)); s.jp = 1'($urandom_range(0, 3) == 0);
      s.pcs    = 2'($urandom_range(0, 3));
      s.rs_ex  = 5'($urandom_range(0, 3)); s.rt_ex = 5'($urandom_range(0, 3));
      s.wr_ex  = 5'($urandom_range(0, 3)); s.rw_ex = 1'($urandom_range(0, 1));
      s.m2r_ex = 1'($urandom_range(0, 2) == 0);
      s.wr_mem = 5'($urandom_range(0, 3)); s.rw_mem = 1'($urandom_range(0, 1));
      s.m2r_mem = 1'($urandom_range(0, 1));
      s.wr_wb  = 5'($urandom_range(0, 3)); s.rw_wb = 1'($urandom_range(0, 1));
      if (m_drop)            s.req = 0;
      else if (m_waited > 0) s.req = 1;
      else                   s.req = ($urandom_range(0, 3) == 0);
      s.rdy    = ($urandom_range(0, 3) == 0);
      drive(s);
    end

    drive(idle());
    repeat (3) @(posedge clock);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
